ssd_display_sched: RTL



---
 rtl/ssd_pkg.sv | 38 +++
 rtl/ssd_display_sched_bin2bcd.sv | 62 ++++++
 rtl/ssd_display_sched.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/ssd_pkg.sv
// Shared types, segment constants and the hex-to-segment helper
// for the seven-segment display scheduler (ssd_display_sched).
package ssd_pkg;

    typedef enum logic {
        SHOW_CREDIT = 1'b0,
        SHOW_MSG    = 1'b1
    } disp_state_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'h7E;
    localparam int         BCD_MAX   = 9999;

    // Active-low {a,b,c,d,e,f,g}
    function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
        logic [6:0] s;
        unique case (h)
            4'h0: s = 7'b0000001;
            4'h1: s = 7'b1001111;
            4'h2: s = 7'b0010010;
            4'h3: s = 7'b0000110;
            4'h4: s = 7'b1001100;
            4'h5: s = 7'b0100100;
            4'h6: s = 7'b0100000;
            4'h7: s = 7'b0001111;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0000100;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b1100000;
            4'hC: s = 7'b0110001;
            4'hD: s = 7'b1000010;
            4'hE: s = 7'b0110000;
            4'hF: s = 7'b0111000;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/ssd_display_sched_bin2bcd.sv
// Sequential shift-add-3 binary to 4-digit BCD converter.
// Ports: clk, reset, start, bin[W-1:0] in; busy, done, bcd[15:0] out.
// start is taken only while idle; one shift per cycle for W cycles,
// then bcd loads on the edge that ends the cycle where done is high.
module bin2bcd_seq
    import ssd_pkg::*;
#(
    parameter int W = 14
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [W-1:0] bin,
    output logic         busy,
    output logic         done,
    output logic [15:0]  bcd
);

    localparam int CW = $clog2(W + 1);

    logic [W-1:0]  sh;
    logic [15:0]   acc;
    logic [15:0]   adj;
    logic [CW-1:0] cnt;

    always_comb begin
        adj = acc;
        for (int i = 0; i < 4; i++) begin
            if (acc[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
            end
        end
    end

    // Final cycle of a run: all W bits have been shifted in.
    assign done = busy && (cnt == CW'(W));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy <= 1'b0;
            cnt  <= '0;
            sh   <= '0;
            acc  <= '0;
            bcd  <= '0;
        end else if (!busy) begin
            if (start) begin
                sh   <= bin;
                acc  <= '0;
                cnt  <= '0;
                busy <= 1'b1;
            end
        end else if (done) begin
            bcd  <= acc;
            busy <= 1'b0;
        end else begin
            acc <= {adj[14:0], sh[W-1]};
            sh  <= {sh[W-2:0], 1'b0};
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/ssd_display_sched.sv
// Display scheduler: credit (binary->BCD) vs. timed hex messages,
// producing registered active-low segments seg3..seg0 (seg0 rightmost).
// Ports: clk, reset, credit_val/credit_upd, msg_req/msg_code in;
//        msg_ack, msg_active, conv_busy, seg3..seg0 out.
// Optional: define SSD_MSG_BLINK_EN to blink messages every BLINK_CYCLES.
module ssd_display_sched
    import ssd_pkg::*;
#(
    parameter int HOLD_CYCLES  = 100000000,
    parameter int BLINK_CYCLES = 25000000,
    parameter int CREDIT_W     = 14
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [CREDIT_W-1:0] credit_val,
    input  logic                credit_upd,
    input  logic                msg_req,
    input  logic [15:0]         msg_code,
    output logic                msg_ack,
    output logic                msg_active,
    output logic                conv_busy,
    output logic [6:0]          seg3,
    output logic [6:0]          seg2,
    output logic [6:0]          seg1,
    output logic [6:0]          seg0
);

    localparam int HW = $clog2(HOLD_CYCLES + 1);

    if (HOLD_CYCLES < 1 || BLINK_CYCLES < 1) begin : g_bad_param
        $error("ssd_display_sched: cycle parameters must be >= 1");
    end

    // ---------------- credit path ----------------
    logic                cbusy;
    logic                cdone;
    logic [15:0]         bcd;
    logic                cstart;
    logic [CREDIT_W-1:0] cbin;
    logic [CREDIT_W-1:0] pend_val;
    logic                pend_vld;
    logic                run_ovf;
    logic                disp_ovf;

    // A fresh update beats a parked one (last one wins).
    assign cstart = !cbusy && (credit_upd || pend_vld);
    assign cbin   = credit_upd ? credit_val : pend_val;

    bin2bcd_seq #(.W(CREDIT_W)) u_conv (
        .clk   (clk),
        .reset (reset),
        .start (cstart),
        .bin   (cbin),
        .busy  (cbusy),
        .done  (cdone),
        .bcd   (bcd)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_vld <= 1'b0;
            pend_val <= '0;
            run_ovf  <= 1'b0;
            disp_ovf <= 1'b0;
        end else begin
            if (cstart) begin
                pend_vld <= 1'b0;
                run_ovf  <= (cbin > CREDIT_W'(BCD_MAX));
            end else if (credit_upd) begin
                pend_vld <= 1'b1;
                pend_val <= credit_val;
            end
            // Overflow flag moves on the same edge the BCD register loads.
            if (cdone) begin
                disp_ovf <= run_ovf;
            end
        end
    end

    assign conv_busy = cbusy || pend_vld;

    logic [27:0] cimg;

    always_comb begin
        cimg[6:0]   = hex_to_seg(bcd[3:0]);
        cimg[13:7]  = (bcd[15:4] == '0) ? SEG_BLANK : hex_to_seg(bcd[7:4]);
        cimg[20:14] = (bcd[15:8] == '0) ? SEG_BLANK : hex_to_seg(bcd[11:8]);
        cimg[27:21] = (bcd[15:12] == '0) ? SEG_BLANK : hex_to_seg(bcd[15:12]);
        if (disp_ovf) begin
            cimg = {4{SEG_DASH}};
        end
    end

    // ---------------- message path ----------------
    disp_state_t state;
    logic [HW-1:0] hold;
    logic [15:0]   msg_lat;
    logic          accept;
    logic [27:0]   mimg;
    logic [27:0]   mview;

    // The ack cycle masks the still-high level request.
    assign accept = msg_req && !msg_ack;

    assign mimg = {hex_to_seg(msg_lat[15:12]), hex_to_seg(msg_lat[11:8]),
                   hex_to_seg(msg_lat[7:4]),   hex_to_seg(msg_lat[3:0])};

`ifdef SSD_MSG_BLINK_EN
    localparam int BW = $clog2(BLINK_CYCLES + 1);

    logic [BW-1:0] bcnt;
    logic          vis;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bcnt <= '0;
            vis  <= 1'b1;
        end else if (accept) begin
            bcnt <= '0;
            vis  <= 1'b1;
        end else if (state == SHOW_MSG) begin
            if (bcnt == BW'(BLINK_CYCLES - 1)) begin
                bcnt <= '0;
                vis  <= !vis;
            end else begin
                bcnt <= bcnt + BW'(1);
            end
        end
    end

    assign mview = vis ? mimg : {4{SEG_BLANK}};
`else
    assign mview = mimg;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= SHOW_CREDIT;
            hold       <= '0;
            msg_lat    <= '0;
            msg_ack    <= 1'b0;
            msg_active <= 1'b0;
            {seg3, seg2, seg1, seg0} <= {4{SEG_BLANK}};
        end else begin
            msg_ack <= accept;
            if (accept) begin
                state   <= SHOW_MSG;
                msg_lat <= msg_code;
                hold    <= HW'(HOLD_CYCLES - 1);
            end else if (state == SHOW_MSG) begin
                if (hold == '0) begin
                    state <= SHOW_CREDIT;
                end else begin
                    hold <= hold - HW'(1);
                end
            end
            msg_active <= (state == SHOW_MSG);
            if (state == SHOW_MSG) begin
                {seg3, seg2, seg1, seg0} <= mview;
            end else begin
                {seg3, seg2, seg1, seg0} <= cimg;
            end
        end
    end

endmodule
